pipe_ctrl: RTL and testbench
============================

# pipe_ctrl

Pipeline control unit for the five-stage MIPS core. It is the producer of the 6-bit `stall` vector consumed by the PC, IF/ID, ID/EX, EX/MEM and MEM/WB latches. It merges per-stage stall requests, runs a debug-halt drain state machine, and runs a stall watchdog. It also keeps free-running performance counters for cycles, stall cycles and inserted bubbles.

## Interface
Parameters:
- `DRAIN_CYCLES`, default 4: cycles spent in DRAIN before HALTED, so that IF-frozen instructions retire through WB.
- `STALL_LIMIT`, default 1024: consecutive hazard-stall cycles before the watchdog trips. Legal range is 1..65535.

Ports:
- `clk`  in  1  clock
- `rst`  in  1  synchronous, active-high reset
- `stallreq_if`  in  1  IF waiting on instruction memory
- `stallreq_id`  in  1  ID load-use / operand hazard
- `stallreq_ex`  in  1  EX multi-cycle op (mult/div) busy
- `stallreq_mem`  in  1  MEM waiting on data memory
- `dbg_halt_req`  in  1  level; request pipeline halt
- `wdt_clr`  in  1  pulse; clear watchdog timeout
- `stall`  out  6  bit0 PC, bit1 IF, bit2 ID, bit3 EX, bit4 MEM, bit5 WB; 1 means hold
- `dbg_halted`  out  1  pipeline fully frozen and drained
- `wdt_timeout`  out  1  sticky watchdog flag
- `cyc_cnt`  out  32  cycles since reset
- `stall_cnt`  out  32  cycles with hazard stall[0]=1
- `bubble_cnt`  out  32  cycles with stall[2]=1 and stall[3]=0

## Operation
- Hazard mask `hz` is the bitwise OR of the masks of the asserted requests:
  - `stallreq_if` → 000011
  - `stallreq_id` → 000111
  - `stallreq_ex` → 001111
  - `stallreq_mem` → 011111
  - none → 000000
- Every mask is a contiguous low prefix, so the OR equals the deepest request. `stall` is always a low prefix.
- Debug FSM states:
  - RUN: `dbg_mask` = 000000.
  - DRAIN: `dbg_mask` = 000011; a drain counter counts up from 0.
  - HALTED: `dbg_mask` = 111111.
- `stall` = `hz` | `dbg_mask`. It is combinational from the inputs and registered state and is valid in the same cycle.
- Debug FSM transitions, evaluated each posedge:
  - RUN → DRAIN when `dbg_halt_req`=1; drain counter loads 0.
  - DRAIN: the drain counter increments only in cycles where `hz[3]`=0, so EX/MEM-held instructions do not count as drained.
  - DRAIN → HALTED when the counter reaches `DRAIN_CYCLES`-1 with `hz[3]`=0.
  - DRAIN → RUN immediately if `dbg_halt_req` drops.
  - HALTED → RUN when `dbg_halt_req`=0.
- `dbg_halted` = 1 exactly while in HALTED.
- Watchdog FSM states:
  - WRUN: consecutive-stall counter `wc` = 0.
  - WSTALL: `wc` counts.
  - WTRIP: `wdt_timeout`=1.
- Watchdog transitions:
  - WRUN → WSTALL when `hz[0]`=1.
  - WSTALL increments `wc` each cycle `hz[0]`=1 and returns to WRUN (`wc`=0) on any cycle `hz[0]`=0.
  - WSTALL → WTRIP on the cycle `wc` reaches `STALL_LIMIT`-1 with `hz[0]` still 1.
  - WTRIP is sticky regardless of `hz`. It exits to WRUN only on `wdt_clr`.
- The watchdog only observes `hz`. Debug stalls never advance it.
- The watchdog never alters `stall`; it is report-only.
- Counters are 32-bit and wrap modulo 2^32, with no saturation:
  - `cyc_cnt` increments every non-reset cycle.
  - `stall_cnt` increments when `hz[0]`=1.
  - `bubble_cnt` increments when the final `stall[2]`=1 and `stall[3]`=0, which is exactly when the ID/EX latch injects a NOP.

## Timing
- Reset values:
  - `stall` = 000000 when all inputs are 0.
  - `dbg_halted`=0 and `wdt_timeout`=0.
  - All counters 0.
  - Debug FSM in RUN, drain counter 0.
  - Watchdog in WRUN, `wc`=0.
- During `rst`, `stall` still reflects `hz`, because it is combinational. The FSMs and counters hold their reset values.
- `stall` has zero latency from `stallreq_*`.
- `dbg_halted` rises `DRAIN_CYCLES`+1 cycles after `dbg_halt_req` is sampled high, when `hz[3]` stays 0 throughout.
- `wdt_timeout` rises on the posedge after `STALL_LIMIT` consecutive `hz[0]`=1 cycles.
- `wdt_clr` with `hz[0]`=1 goes to WRUN. WSTALL is re-entered on the next cycle and `wc` restarts from 0.
- Simultaneous `dbg_halt_req` drop and drain completion: RUN wins.
- Reset mid-DRAIN or mid-WTRIP returns both FSMs to their reset state on the next posedge.

## Test plan
- `stallreq_id`=1 alone → `stall`=000111 in the same cycle. `bubble_cnt` +1 per cycle and `stall_cnt` +1 per cycle.
- `stallreq_id`=1 and `stallreq_mem`=1 together → `stall`=011111. `bubble_cnt` unchanged.
- `dbg_halt_req` held high with no hazards, `DRAIN_CYCLES`=4:
  - `stall`=000011 for cycles 1–4.
  - `dbg_halted`=1 and `stall`=111111 from cycle 5.
  - Dropping the request → RUN and `stall`=000000 on the next cycle.
- `dbg_halt_req` during DRAIN with `stallreq_ex` high for 3 cycles → HALTED is delayed by exactly 3 cycles.
- `STALL_LIMIT`=8:
  - `stallreq_if` high for 7 cycles, then 0 → no trip.
  - `stallreq_if` high for 8 cycles → `wdt_timeout`=1, sticky after the request drops.
  - `wdt_clr` → `wdt_timeout`=0.
- Force `cyc_cnt` to 0xFFFFFFFF via a hierarchical deposit, then one cycle → `cyc_cnt` reads 0x00000000.

Source files
------------

// File: rtl/pipe_ctrl.sv
// Pipeline control unit: merges per-stage stall requests into a low-prefix
// stall vector, drains and halts the pipe on debug request, watches for
// runaway hazard stalls, and keeps free-running performance counters.
module pipe_ctrl #(
    parameter int unsigned DRAIN_CYCLES = 4,
    parameter int unsigned STALL_LIMIT  = 1024
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stallreq_if,
    input  logic        stallreq_id,
    input  logic        stallreq_ex,
    input  logic        stallreq_mem,
    input  logic        dbg_halt_req,
    input  logic        wdt_clr,
    output logic [5:0]  stall,
    output logic        dbg_halted,
    output logic        wdt_timeout,
    output logic [31:0] cyc_cnt,
    output logic [31:0] stall_cnt,
    output logic [31:0] bubble_cnt
);

    localparam int unsigned DCW = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
    localparam logic [DCW-1:0] DRAIN_LAST = DCW'(DRAIN_CYCLES - 1);
    localparam logic [15:0] WC_LAST = 16'(STALL_LIMIT - 1);

    typedef enum logic [1:0] {DbgRun, DbgDrain, DbgHalted} dbg_state_t;
    typedef enum logic [1:0] {WdtRun, WdtStall, WdtTrip} wdt_state_t;

    dbg_state_t     dbg_state;
    logic [DCW-1:0] drain_cnt;
    wdt_state_t     wdt_state;
    logic [15:0]    wc;
    logic [5:0]     hz;
    logic [5:0]     dbg_mask;

    // Hazard mask: each request freezes its own stage and everything upstream.
    always_comb begin
        hz = 6'b000000;
        if (stallreq_if)  hz = hz | 6'b000011;
        if (stallreq_id)  hz = hz | 6'b000111;
        if (stallreq_ex)  hz = hz | 6'b001111;
        if (stallreq_mem) hz = hz | 6'b011111;
    end

    // Debug mask from the registered FSM state; final stall merges both masks.
    always_comb begin
        dbg_mask = 6'b000000;
        unique case (dbg_state)
            DbgDrain:  dbg_mask = 6'b000011;
            DbgHalted: dbg_mask = 6'b111111;
            default:   dbg_mask = 6'b000000;
        endcase
        stall = hz | dbg_mask;
    end

    // Debug halt FSM: freeze fetch, let in-flight instructions retire, then halt.
    always_ff @(posedge clk) begin
        if (rst) begin
            dbg_state  <= DbgRun;
            drain_cnt  <= '0;
            dbg_halted <= 1'b0;
        end else begin
            unique case (dbg_state)
                DbgRun: begin
                    if (dbg_halt_req) begin
                        dbg_state <= DbgDrain;
                        drain_cnt <= '0;
                    end
                end
                DbgDrain: begin
                    // A dropped request takes priority over drain completion.
                    if (!dbg_halt_req) begin
                        dbg_state <= DbgRun;
                        drain_cnt <= '0;
                    end else if (!hz[3]) begin
                        // Cycles with EX/MEM held do not retire anything.
                        if (drain_cnt == DRAIN_LAST) begin
                            dbg_state  <= DbgHalted;
                            dbg_halted <= 1'b1;
                        end else begin
                            drain_cnt <= drain_cnt + 1'b1;
                        end
                    end
                end
                DbgHalted: begin
                    if (!dbg_halt_req) begin
                        dbg_state  <= DbgRun;
                        dbg_halted <= 1'b0;
                        drain_cnt  <= '0;
                    end
                end
                default: begin
                    dbg_state  <= DbgRun;
                    dbg_halted <= 1'b0;
                    drain_cnt  <= '0;
                end
            endcase
        end
    end

    // Stall watchdog: counts consecutive hazard stalls, trips and stays tripped.
    always_ff @(posedge clk) begin
        if (rst) begin
            wdt_state   <= WdtRun;
            wc          <= '0;
            wdt_timeout <= 1'b0;
        end else begin
            unique case (wdt_state)
                WdtRun: begin
                    wc <= '0;
                    if (hz[0]) begin
                        // The entering cycle is the first stalled cycle counted.
                        if (STALL_LIMIT == 1) begin
                            wdt_state   <= WdtTrip;
                            wdt_timeout <= 1'b1;
                        end else begin
                            wdt_state <= WdtStall;
                            wc        <= 16'd1;
                        end
                    end
                end
                WdtStall: begin
                    if (!hz[0]) begin
                        wdt_state <= WdtRun;
                        wc        <= '0;
                    end else if (wc == WC_LAST) begin
                        wdt_state   <= WdtTrip;
                        wdt_timeout <= 1'b1;
                        wc          <= '0;
                    end else begin
                        wc <= wc + 16'd1;
                    end
                end
                WdtTrip: begin
                    if (wdt_clr) begin
                        wdt_state   <= WdtRun;
                        wdt_timeout <= 1'b0;
                    end
                end
                default: begin
                    wdt_state   <= WdtRun;
                    wc          <= '0;
                    wdt_timeout <= 1'b0;
                end
            endcase
        end
    end

    // Free-running performance counters, wrapping modulo 2^32.
    always_ff @(posedge clk) begin
        if (rst) begin
            cyc_cnt    <= '0;
            stall_cnt  <= '0;
            bubble_cnt <= '0;
        end else begin
            cyc_cnt <= cyc_cnt + 32'd1;
            if (hz[0]) begin
                stall_cnt <= stall_cnt + 32'd1;
            end
            // ID/EX injects a NOP exactly when ID holds but EX advances.
            if (stall[2] && !stall[3]) begin
                bubble_cnt <= bubble_cnt + 32'd1;
            end
        end
    end

endmodule

// File: tb/tb_pipe_ctrl.sv
// Bench for pipe_ctrl: behavioural model compared every cycle, plus directed
// literal checks of the stall vector, halt timing, watchdog and counter wrap.
module tb_pipe_ctrl;

    localparam int unsigned DRAIN = 4;
    localparam int unsigned LIMIT = 8;

    logic        clk;
    logic        rst;
    logic        stallreq_if, stallreq_id, stallreq_ex, stallreq_mem;
    logic        dbg_halt_req, wdt_clr;
    logic [5:0]  stall;
    logic        dbg_halted, wdt_timeout;
    logic [31:0] cyc_cnt, stall_cnt, bubble_cnt;

    int checks = 0;
    int errors = 0;
    bit checking = 0;

    // Model state: abstract counts of history rather than FSM states.
    int          m_req_len = 0;   // consecutive sampled cycles with halt request
    int          m_quiet   = 0;   // drain cycles with EX not held
    int          m_run     = 0;   // consecutive hazard-stall cycles
    bit          m_trip    = 0;
    logic [31:0] m_cyc     = '0;
    logic [31:0] m_stc     = '0;
    logic [31:0] m_bub     = '0;

    pipe_ctrl #(
        .DRAIN_CYCLES(DRAIN),
        .STALL_LIMIT (LIMIT)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .stallreq_if (stallreq_if),
        .stallreq_id (stallreq_id),
        .stallreq_ex (stallreq_ex),
        .stallreq_mem(stallreq_mem),
        .dbg_halt_req(dbg_halt_req),
        .wdt_clr     (wdt_clr),
        .stall       (stall),
        .dbg_halted  (dbg_halted),
        .wdt_timeout (wdt_timeout),
        .cyc_cnt     (cyc_cnt),
        .stall_cnt   (stall_cnt),
        .bubble_cnt  (bubble_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got 0x%0h expected 0x%0h", name, $time, act, exp);
        end
    endtask

    // Deepest requesting stage decides how many low stages are frozen.
    function automatic logic [5:0] model_hz(input logic i, input logic d, input logic e,
                                            input logic m);
        int depth;
        depth = m ? 5 : e ? 4 : d ? 3 : i ? 2 : 0;
        return 6'((1 << depth) - 1);
    endfunction

    // Compare mid-cycle (inputs settled), then advance the model over the next edge.
    always @(negedge clk) begin
        logic [5:0] hz_m, s_m;
        bit halted_m, drain_m;
        #2;
        hz_m     = model_hz(stallreq_if, stallreq_id, stallreq_ex, stallreq_mem);
        halted_m = (m_quiet >= DRAIN);
        drain_m  = (m_req_len > 0) && !halted_m;
        s_m      = hz_m | (halted_m ? 6'b111111 : drain_m ? 6'b000011 : 6'b000000);
        if (checking) begin
            check("stall", 32'(stall), 32'(s_m));
            check("dbg_halted", 32'(dbg_halted), 32'(halted_m));
            check("wdt_timeout", 32'(wdt_timeout), 32'(m_trip));
            check("cyc_cnt", cyc_cnt, m_cyc);
            check("stall_cnt", stall_cnt, m_stc);
            check("bubble_cnt", bubble_cnt, m_bub);
        end
        if (rst) begin
            m_req_len = 0; m_quiet = 0; m_run = 0; m_trip = 0;
            m_cyc = '0; m_stc = '0; m_bub = '0;
        end else begin
            if (!dbg_halt_req) begin
                m_req_len = 0;
                m_quiet   = 0;
            end else begin
                if (m_req_len > 0 && !halted_m && !hz_m[3]) m_quiet++;
                if (m_req_len < 1000000) m_req_len++;
            end
            if (m_trip) begin
                if (wdt_clr) begin
                    m_trip = 0;
                    m_run  = 0;
                end
            end else if (hz_m[0]) begin
                m_run++;
                if (m_run >= LIMIT) begin
                    m_trip = 1;
                    m_run  = 0;
                end
            end else begin
                m_run = 0;
            end
            m_cyc = m_cyc + 32'd1;
            if (hz_m[0]) m_stc = m_stc + 32'd1;
            if (s_m[2] && !s_m[3]) m_bub = m_bub + 32'd1;
        end
    end

    task automatic tick();
        @(negedge clk);
    endtask

    initial begin
        rst = 1'b1;
        {stallreq_if, stallreq_id, stallreq_ex, stallreq_mem, dbg_halt_req, wdt_clr} = '0;
        tick(); tick();
        rst = 1'b0;
        #1;
        check("rst_stall", 32'(stall), 32'h0);
        check("rst_halted", 32'(dbg_halted), 32'h0);
        check("rst_wdt", 32'(wdt_timeout), 32'h0);
        check("rst_cyc", cyc_cnt, 32'd0);
        check("rst_bubble", bubble_cnt, 32'd0);
        checking = 1;

        // ID hazard alone, then ID+MEM together.
        tick(); stallreq_id = 1'b1; #1;
        check("id_stall", 32'(stall), 32'b000111);
        tick(); tick(); tick();
        stallreq_mem = 1'b1; #1;
        check("idmem_stall", 32'(stall), 32'b011111);
        check("id_bubble3", bubble_cnt, 32'd3);
        check("id_stallcnt3", stall_cnt, 32'd3);
        tick(); tick();
        stallreq_id = 1'b0; stallreq_mem = 1'b0; #1;
        check("idmem_bubble", bubble_cnt, 32'd3);
        check("idmem_stallcnt", stall_cnt, 32'd5);
        check("cyc6", cyc_cnt, 32'd6);
        check("idle_stall", 32'(stall), 32'h0);

        // Clean debug halt: four drain cycles, halted from cycle five.
        tick(); dbg_halt_req = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            tick(); #1;
            check("drain_stall", 32'(stall), 32'b000011);
            check("drain_halted", 32'(dbg_halted), 32'h0);
        end
        tick(); #1;
        check("halted", 32'(dbg_halted), 32'h1);
        check("halted_stall", 32'(stall), 32'b111111);
        dbg_halt_req = 1'b0;
        tick(); #1;
        check("resume_stall", 32'(stall), 32'h0);
        check("resume_halted", 32'(dbg_halted), 32'h0);

        // Halt with EX busy for three drain cycles: halted three cycles later.
        tick(); dbg_halt_req = 1'b1;
        tick(); stallreq_ex = 1'b1;
        tick(); tick(); tick(); stallreq_ex = 1'b0;
        tick(); tick(); tick(); #1;
        check("ex_halt_early", 32'(dbg_halted), 32'h0);
        tick(); #1;
        check("ex_halt_late", 32'(dbg_halted), 32'h1);
        dbg_halt_req = 1'b0;
        tick();

        // Watchdog: seven stalls do not trip, eight do.
        stallreq_if = 1'b1;
        repeat (7) tick();
        stallreq_if = 1'b0; #1;
        check("wdt_7", 32'(wdt_timeout), 32'h0);
        tick(); #1;
        check("wdt_7_after", 32'(wdt_timeout), 32'h0);
        stallreq_if = 1'b1;
        repeat (7) tick(); #1;
        check("wdt_pre", 32'(wdt_timeout), 32'h0);
        tick(); #1;
        check("wdt_trip", 32'(wdt_timeout), 32'h1);
        stallreq_if = 1'b0;
        tick(); #1;
        check("wdt_sticky", 32'(wdt_timeout), 32'h1);
        wdt_clr = 1'b1;
        tick(); wdt_clr = 1'b0; #1;
        check("wdt_clr", 32'(wdt_timeout), 32'h0);

        // Clear while still stalled: count restarts from zero.
        stallreq_if = 1'b1;
        repeat (8) tick();
        wdt_clr = 1'b1;
        tick(); wdt_clr = 1'b0; #1;
        check("wdt_clr_busy", 32'(wdt_timeout), 32'h0);
        repeat (7) tick(); #1;
        check("wdt_restart_pre", 32'(wdt_timeout), 32'h0);
        tick(); #1;
        check("wdt_restart_trip", 32'(wdt_timeout), 32'h1);
        stallreq_if = 1'b0; wdt_clr = 1'b1;
        tick(); wdt_clr = 1'b0;

        // Reset in the middle of a drain.
        dbg_halt_req = 1'b1;
        tick(); tick();
        rst = 1'b1;
        tick();
        rst = 1'b0; dbg_halt_req = 1'b0; #1;
        check("rst_mid_stall", 32'(stall), 32'h0);
        check("rst_mid_cyc", cyc_cnt, 32'd0);

        // Cycle counter wrap.
        tick();
        dut.cyc_cnt = 32'hFFFF_FFFF;
        m_cyc = 32'hFFFF_FFFF;
        tick(); #1;
        check("cyc_wrap", cyc_cnt, 32'h0000_0000);
        tick(); tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
